// File: rtl/bank_serializer.sv
// bank_serializer: accepts a whole frame of NUM_BANKS bank values in one
// handshake and plays it out as NUM_BEATS beats of OUT_WIDTH lanes each.
// Two frame slots (drain + hold) let the next frame queue up behind the
// one being drained, so back-to-back frames stream with no bubble.
module bank_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_BANKS  = 40,
    parameter int OUT_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_data [NUM_BANKS],
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data [OUT_WIDTH],
    output logic [OUT_WIDTH-1:0]  m_keep,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [15:0]           frames_done
);

    localparam int NUM_BEATS = (NUM_BANKS + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int PAD_BANKS = NUM_BEATS * OUT_WIDTH;
    localparam int BEAT_W    = $clog2(NUM_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    // Frame storage; contents are qualified by the full flags, so no reset.
    logic [DATA_WIDTH-1:0] drain_reg [NUM_BANKS];
    logic [DATA_WIDTH-1:0] hold_reg  [NUM_BANKS];
    // Drain slot viewed as a whole number of beats; pad lanes read as zero.
    logic [DATA_WIDTH-1:0] padded    [PAD_BANKS];

    logic              drain_full_reg, drain_full_next;
    logic              hold_full_reg,  hold_full_next;
    logic [BEAT_W-1:0] beat_reg,       beat_next;
    logic [15:0]       frames_done_reg, frames_done_next;

    logic in_hs, out_hs, last_hs;
    logic load_drain, load_hold, move_hold;

    assign s_ready     = !hold_full_reg;
    assign m_valid     = drain_full_reg;
    assign m_last      = drain_full_reg && (beat_reg == LAST_BEAT);
    assign frames_done = frames_done_reg;

    assign in_hs   = s_valid && s_ready;
    assign out_hs  = m_valid && m_ready;
    assign last_hs = out_hs && (beat_reg == LAST_BEAT);

    // A new frame goes straight to the drain slot when it is free this edge;
    // otherwise it waits in the hold slot. Hold is only ever loaded while
    // s_ready is high, so load_hold and move_hold never coincide.
    assign load_drain = in_hs && (!drain_full_reg || last_hs);
    assign load_hold  = in_hs && drain_full_reg && !last_hs;
    assign move_hold  = last_hs && hold_full_reg;

    // Next-state for slot flags, beat counter and completed-frame counter.
    always_comb begin
        drain_full_next  = drain_full_reg;
        hold_full_next   = hold_full_reg;
        beat_next        = beat_reg;
        frames_done_next = frames_done_reg;
        if (load_drain || move_hold) begin
            drain_full_next = 1'b1;
        end else if (last_hs) begin
            drain_full_next = 1'b0;
        end
        if (move_hold) begin
            hold_full_next = 1'b0;
        end else if (load_hold) begin
            hold_full_next = 1'b1;
        end
        if (last_hs) begin
            beat_next        = '0;
            frames_done_next = frames_done_reg + 16'd1;
        end else if (out_hs) begin
            beat_next = beat_reg + 1'b1;
        end
    end

    // Control state register; reset discards both slots at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_full_reg  <= 1'b0;
            hold_full_reg   <= 1'b0;
            beat_reg        <= '0;
            frames_done_reg <= '0;
        end else begin
            drain_full_reg  <= drain_full_next;
            hold_full_reg   <= hold_full_next;
            beat_reg        <= beat_next;
            frames_done_reg <= frames_done_next;
        end
    end

    // Frame capture: s_data is sampled only on an input handshake.
    always_ff @(posedge clk) begin
        if (move_hold) begin
            drain_reg <= hold_reg;
        end else if (load_drain) begin
            drain_reg <= s_data;
        end
        if (load_hold) begin
            hold_reg <= s_data;
        end
    end

    generate
        for (genvar gi = 0; gi < PAD_BANKS; gi++) begin : g_pad
            if (gi < NUM_BANKS) begin : g_real
                assign padded[gi] = drain_reg[gi];
            end else begin : g_zero
                assign padded[gi] = '0;
            end
        end

        for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] lane_data;
            logic                  lane_keep;

            // Select this lane's bank for the current beat; idle lanes read zero.
            always_comb begin
                lane_data = '0;
                lane_keep = 1'b0;
                if (drain_full_reg) begin
                    for (int b = 0; b < NUM_BEATS; b++) begin
                        if (beat_reg == BEAT_W'(b)) begin
                            lane_data = padded[b * OUT_WIDTH + gi];
                            lane_keep = ((b * OUT_WIDTH + gi) < NUM_BANKS);
                        end
                    end
                end
            end

            assign m_data[gi] = lane_data;
            assign m_keep[gi] = lane_keep;
        end
    endgenerate

endmodule

// File: tb/tb_bank_serializer.sv
// Bench for bank_serializer: three instances (default 40x1, 40 banks over
// 3 lanes, 1x1 for counter wrap). Expected beats are queued when a frame is
// accepted and popped by per-instance monitors on each output handshake.
module tb_bank_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // dut0: defaults
    logic [15:0] s_data0 [40];
    logic        s_valid0, s_ready0, m_valid0, m_ready0, m_last0;
    logic [15:0] m_data0 [1];
    logic [0:0]  m_keep0;
    logic [15:0] frames_done0;

    // dut1: three lanes
    logic [15:0] s_data1 [40];
    logic        s_valid1, s_ready1, m_valid1, m_ready1, m_last1;
    logic [15:0] m_data1 [3];
    logic [2:0]  m_keep1;
    logic [15:0] frames_done1;

    // dut2: single bank, single lane
    logic [15:0] s_data2 [1];
    logic        s_valid2, s_ready2, m_valid2, m_ready2, m_last2;
    logic [15:0] m_data2 [1];
    logic [0:0]  m_keep2;
    logic [15:0] frames_done2;

    bank_serializer u_dut0 (
        .clk(clk), .reset_n(reset_n), .s_data(s_data0), .s_valid(s_valid0),
        .s_ready(s_ready0), .m_data(m_data0), .m_keep(m_keep0), .m_valid(m_valid0),
        .m_ready(m_ready0), .m_last(m_last0), .frames_done(frames_done0)
    );

    bank_serializer #(.DATA_WIDTH(16), .NUM_BANKS(40), .OUT_WIDTH(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .s_data(s_data1), .s_valid(s_valid1),
        .s_ready(s_ready1), .m_data(m_data1), .m_keep(m_keep1), .m_valid(m_valid1),
        .m_ready(m_ready1), .m_last(m_last1), .frames_done(frames_done1)
    );

    bank_serializer #(.DATA_WIDTH(16), .NUM_BANKS(1), .OUT_WIDTH(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .s_data(s_data2), .s_valid(s_valid2),
        .s_ready(s_ready2), .m_data(m_data2), .m_keep(m_keep2), .m_valid(m_valid2),
        .m_ready(m_ready2), .m_last(m_last2), .frames_done(frames_done2)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [47:0] data;
        logic [2:0]  keep;
        logic        last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t e0, e1;
    int    hs0 = 0;
    int    hs1 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // dut0 monitor: scoreboard compare plus stall stability
    logic        stall0 = 1'b0;
    logic [15:0] sd0;
    logic        sk0, sl0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (stall0) begin
                chk("stall_valid0", m_valid0, 1);
                chk("stall_data0", m_data0[0], sd0);
                chk("stall_keep0", m_keep0, sk0);
                chk("stall_last0", m_last0, sl0);
            end
            if (m_valid0 && m_ready0) begin
                chk("beat_expected0", q0.size() > 0, 1);
                if (q0.size() > 0) begin
                    e0 = q0.pop_front();
                    chk("data0", m_data0[0], e0.data[15:0]);
                    chk("keep0", m_keep0, e0.keep[0]);
                    chk("last0", m_last0, e0.last);
                end
                hs0++;
            end
            stall0 = m_valid0 && !m_ready0;
            sd0    = m_data0[0];
            sk0    = m_keep0[0];
            sl0    = m_last0;
        end else begin
            stall0 = 1'b0;
        end
    end

    // dut1 monitor: scoreboard compare of all three lanes
    always @(negedge clk) begin
        if (reset_n && m_valid1 && m_ready1) begin
            chk("beat_expected1", q1.size() > 0, 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("data1", {m_data1[2], m_data1[1], m_data1[0]}, e1.data);
                chk("keep1", m_keep1, e1.keep);
                chk("last1", m_last1, e1.last);
            end
            hs1++;
        end
    end

    task automatic send0(input int base);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) s_data0[i] = 16'(base + i);
        s_valid0 = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            ok = s_ready0;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        s_valid0 = 1'b0;
        chk("accept0", ok, 1);
        if (ok) begin
            for (int b = 0; b < 40; b++) begin
                beat_t t;
                t.data = 48'(base + b);
                t.keep = 3'b001;
                t.last = (b == 39);
                q0.push_back(t);
            end
            $display("dut0 frame base=%0d accepted at %0t", base, $time);
        end
    endtask

    task automatic send1(input int base);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) s_data1[i] = 16'(base + i);
        s_valid1 = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            ok = s_ready1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        s_valid1 = 1'b0;
        chk("accept1", ok, 1);
        if (ok) begin
            for (int b = 0; b < 14; b++) begin
                beat_t t;
                t.data = '0;
                t.keep = '0;
                for (int j = 0; j < 3; j++) begin
                    if (3 * b + j < 40) begin
                        t.data[16*j +: 16] = 16'(base + 3 * b + j);
                        t.keep[j]          = 1'b1;
                    end
                end
                t.last = (b == 13);
                q1.push_back(t);
            end
            $display("dut1 frame base=%0d accepted at %0t", base, $time);
        end
    endtask

    task automatic wait_drain0();
        int n;
        for (n = 0; n < 500; n++) begin
            @(posedge clk);
            #1;
            if (q0.size() == 0 && !m_valid0) break;
        end
        chk("drain0_in_time", n < 500, 1);
    endtask

    task automatic wait_drain1();
        int n;
        for (n = 0; n < 500; n++) begin
            @(posedge clk);
            #1;
            if (q1.size() == 0 && !m_valid1) break;
        end
        chk("drain1_in_time", n < 500, 1);
    endtask

    initial begin
        int hs_start;
        int cycles;
        int acc;

        reset_n  = 1'b0;
        s_valid0 = 1'b0; s_valid1 = 1'b0; s_valid2 = 1'b0;
        m_ready0 = 1'b1; m_ready1 = 1'b1; m_ready2 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_data0[i] = '0;
            s_data1[i] = '0;
        end
        s_data2[0] = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid0", m_valid0, 0);
        chk("rst_last0", m_last0, 0);
        chk("rst_keep0", m_keep0, 0);
        chk("rst_data0", m_data0[0], 0);
        chk("rst_done0", frames_done0, 0);
        chk("rst_ready0", s_ready0, 1);
        chk("rst_valid1", m_valid1, 0);
        chk("rst_keep1", m_keep1, 0);
        chk("rst_ready1", s_ready1, 1);
        chk("rst_done2", frames_done2, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // single frame, values 1..40, one-cycle latency
        hs_start = hs0;
        send0(1);
        chk("latency_valid0", m_valid0, 1);
        chk("latency_data0", m_data0[0], 1);
        wait_drain0();
        chk("beats_frame0", hs0 - hs_start, 40);
        chk("done_after_1", frames_done0, 1);
        chk("idle_data0", m_data0[0], 0);
        chk("idle_keep0", m_keep0, 0);
        chk("idle_last0", m_last0, 0);

        // frame A then frame B queued behind it
        send0(100);
        send0(200);
        for (int i = 0; i < 39; i++) begin
            @(negedge clk);
            chk("held_sready0", s_ready0, 0);
            chk("held_valid0", m_valid0, 1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("b_sready0", s_ready0, 1);
        chk("b_valid0", m_valid0, 1);
        chk("b_first0", m_data0[0], 200);
        wait_drain0();
        chk("done_after_ab", frames_done0, 3);

        // m_ready toggling: 2 cycles per beat
        send0(1);
        m_ready0 = 1'b0;
        cycles   = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            cycles++;
            m_ready0 = ~m_ready0;
            if (!m_valid0) break;
        end
        m_ready0 = 1'b1;
        chk("toggle_cycles", cycles, 80);
        chk("toggle_queue_empty", q0.size(), 0);
        chk("done_after_toggle", frames_done0, 4);

        // reset in the middle of a frame
        hs_start = hs0;
        send0(1);
        repeat (10) @(posedge clk);
        #1;
        chk("beats_before_reset", hs0 - hs_start, 10);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid0", m_valid0, 0);
        chk("midrst_sready0", s_ready0, 1);
        chk("midrst_done0", frames_done0, 0);
        chk("midrst_data0", m_data0[0], 0);
        q0.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send0(1);
        chk("restart_data0", m_data0[0], 1);
        wait_drain0();
        chk("done_after_restart", frames_done0, 1);

        // three lanes, 14 beats, padded final beat
        hs_start = hs1;
        send1(1);
        chk("w3_beat0", {m_data1[2], m_data1[1], m_data1[0]}, {16'd3, 16'd2, 16'd1});
        chk("w3_keep0", m_keep1, 3'b111);
        wait_drain1();
        chk("w3_beats", hs1 - hs_start, 14);
        chk("w3_done", frames_done1, 1);

        // frames_done wrap with a one-beat frame every cycle
        s_data2[0] = 16'h0055;
        s_valid2   = 1'b1;
        acc        = 0;
        for (int n = 0; n < 65536; n++) begin
            @(negedge clk);
            if (s_ready2) acc++;
            @(posedge clk);
        end
        #1;
        s_valid2 = 1'b0;
        $display("dut2 burst of %0d one-beat frames accepted by %0t", acc, $time);
        chk("wrap_accepts", acc, 65536);
        chk("wrap_pre_done", frames_done2, 16'hFFFF);
        chk("wrap_pre_valid", m_valid2, 1);
        chk("wrap_pre_last", m_last2, 1);
        chk("wrap_pre_data", m_data2[0], 16'h0055);
        @(posedge clk);
        #1;
        chk("wrap_done", frames_done2, 0);
        chk("wrap_valid", m_valid2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
